// File: rtl/k_and_s_datapath.sv
// -----------------------------------------------------------------------------
// k_and_s_datapath
//   Datapath half of the K&S processor. It holds the program counter, the
//   instruction register, a 4x16 register file, the ALU and the flag register.
//   It carries out the strobes issued by the control unit and returns the
//   decoded instruction and the registered flags. It also drives the address
//   and write data of the single-port program/data RAM.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 synchronous, active-high reset
//   branch              1: next PC = IR[7:0], 0: next PC = PC + 1
//   pc_enable           load next PC
//   ir_enable           IR <= ram_rdata
//   write_reg_enable    write register file at the decoded destination
//   addr_sel            0: ram_addr = PC, 1: ram_addr = IR[7:0]
//   c_sel               register write data: 0 = ram_rdata, 1 = ALU result
//   operation           ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable    latch zero/neg/ov/sov from the ALU
//   ram_rdata           RAM read data (instruction or operand)
//   ram_addr            RAM address
//   ram_wdata           RAM write data = R[IR[9:8]]
//   decoded_instruction combinational decode of IR
//   reg_zero/neg/ov/sov registered flags
// -----------------------------------------------------------------------------
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_BRANCH,
      I_BZERO,
      I_BNEG,
      I_HALT
   } decoded_instruction_type;

endpackage

module k_and_s_datapath
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   input  logic [DATA_W-1:0]       ram_rdata,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_wdata,
   output decoded_instruction_type decoded_instruction,
   output logic                    reg_zero,
   output logic                    reg_neg,
   output logic                    reg_ov,
   output logic                    reg_sov
);

   localparam int MSB = DATA_W - 1;

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] regs [4];

   logic [1:0]        a_idx;
   logic [1:0]        b_idx;
   logic [1:0]        dest_idx;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] b_val;
   logic [DATA_W:0]   add_full;
   logic [DATA_W:0]   sub_full;
   logic [DATA_W-1:0] alu_res;
   logic              alu_ov;
   logic              alu_sov;
   logic [DATA_W-1:0] reg_wdata;

   // ---------------------------------------------------------------------------
   // Instruction decode from the opcode byte IR[15:8]
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      decoded_instruction = I_NOP;
      case (ir[15:8])
         8'h80, 8'h81, 8'h82, 8'h83: decoded_instruction = I_LOAD;
         8'h84, 8'h85, 8'h86, 8'h87: decoded_instruction = I_STORE;
         8'h90:                      decoded_instruction = I_MOVE;
         8'hA1:                      decoded_instruction = I_ADD;
         8'hA2:                      decoded_instruction = I_SUB;
         8'hA3:                      decoded_instruction = I_AND;
         8'hA4:                      decoded_instruction = I_OR;
         8'h01:                      decoded_instruction = I_BRANCH;
         8'h02:                      decoded_instruction = I_BZERO;
         8'h03:                      decoded_instruction = I_BNEG;
         8'hFF:                      decoded_instruction = I_HALT;
         default:                    decoded_instruction = I_NOP;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Operand and destination selection
   //   MOVE reads its source on both ALU inputs so OR-with-itself copies it.
   // ---------------------------------------------------------------------------
   always_comb begin
      a_idx    = ir[3:2];
      b_idx    = ir[1:0];
      dest_idx = ir[9:8];
      case (decoded_instruction)
         I_MOVE: begin
            a_idx    = ir[1:0];
            dest_idx = ir[3:2];
         end
         I_ADD, I_SUB, I_AND, I_OR: dest_idx = ir[5:4];
         default: ;
      endcase
   end

   assign a_val = regs[a_idx];
   assign b_val = regs[b_idx];

   // ---------------------------------------------------------------------------
   // ALU: the extra top bit of add_full/sub_full is carry-out / borrow
   // ---------------------------------------------------------------------------
   always_comb begin
      add_full = {1'b0, a_val} + {1'b0, b_val};
      sub_full = {1'b0, a_val} - {1'b0, b_val};
      alu_res  = '0;
      alu_ov   = 1'b0;
      alu_sov  = 1'b0;
      case (operation)
         2'b00: alu_res = a_val | b_val;
         2'b01: begin
            alu_res = add_full[MSB:0];
            alu_ov  = add_full[DATA_W];
            alu_sov = (a_val[MSB] == b_val[MSB]) && (alu_res[MSB] != a_val[MSB]);
         end
         2'b10: begin
            alu_res = sub_full[MSB:0];
            alu_ov  = sub_full[DATA_W];
            alu_sov = (a_val[MSB] != b_val[MSB]) && (alu_res[MSB] != a_val[MSB]);
         end
         default: alu_res = a_val & b_val;
      endcase
   end

   assign reg_wdata = c_sel ? alu_res : ram_rdata;

   // ---------------------------------------------------------------------------
   // RAM interface
   // ---------------------------------------------------------------------------
   assign ram_addr  = addr_sel ? ir[ADDR_W-1:0] : pc;
   assign ram_wdata = regs[ir[9:8]];

   // ---------------------------------------------------------------------------
   // State: PC, IR, register file, flags
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; a read of a register written this cycle therefore
   // still sees the old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= '0;
         ir       <= '0;
         // NOTE: the register file is only four words, so it is built from
         // flops and reset explicitly; a RAM macro could not be cleared here.
         for (int i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
         reg_zero <= 1'b0;
         reg_neg  <= 1'b0;
         reg_ov   <= 1'b0;
         reg_sov  <= 1'b0;
      end else begin
         if (pc_enable) begin
            pc <= branch ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
         end
         if (ir_enable) begin
            ir <= ram_rdata;
         end
         if (write_reg_enable) begin
            regs[dest_idx] <= reg_wdata;
         end
         if (flags_reg_enable) begin
            reg_zero <= (alu_res == '0);
            reg_neg  <= alu_res[MSB];
            reg_ov   <= alu_ov;
            reg_sov  <= alu_sov;
         end
      end
   end

endmodule
